mipi_rx_lane_deskew: RTL and testbench

Parametrised multi-lane deskew stage for the MIPI CSI-2 receive path. It sits between the per-lane byte aligners and the packet decoder, all in the MIPI byte-clock domain. It measures each active lane's arrival offset at start of transmission and re-times all lanes through a shared delay line so that byte n of every lane leaves in the same word. Over the previous fixed 4-lane aligner it adds:
- run-time lane count selection;
- a measured per-lane skew report;
- a skew-overflow error;
- end-of-packet timing derived from a single reference lane.

---
 rtl/mipi_rx_lane_deskew.sv | 151 +++++++++++++++
 tb/tb_mipi_rx_lane_deskew.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_rx_lane_deskew.sv
// CSI-2 multi-lane deskew: measures each enabled lane's arrival offset at start
// of transmission and re-times all lanes through a shared delay line.
module mipi_rx_lane_deskew #(
   parameter int unsigned LANES       = 4,
   parameter int unsigned ALIGN_DEPTH = 8
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [LANES-1:0]     lanes_en_i,
   input  logic [LANES-1:0]     bytes_valid_i,
   input  logic [8*LANES-1:0]   byte_i,
   output logic                 lane_valid_o,
   output logic [8*LANES-1:0]   lane_byte_o,
   output logic [4*LANES-1:0]   lane_skew_o,
   output logic                 skew_err_o
);

   localparam int unsigned DW = 8 * LANES;
   localparam int unsigned TW = $clog2(ALIGN_DEPTH);
   localparam int unsigned RW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [3:0] CNT_LAST = 4'(ALIGN_DEPTH - 1);

   typedef enum logic [2:0] {IDLE, ARM, ALIGNED, DRAIN, ERROR} state_t;

   state_t                     state_q, state_d;
   logic [DW-1:0]              dly_q [ALIGN_DEPTH];
   logic [LANES-1:0]           mask_q, seen_q, seen_d, en_c;
   logic [LANES-1:0][3:0]      off_q, off_d;
   logic [LANES-1:0][TW-1:0]   tap_q;
   logic [3:0]                 cnt_q, cnt_d, maxoff_c;
   logic [RW-1:0]              ref_q, ref_d;
   logic                       load_c, err_d, found_c;

   // Next state, arrival bookkeeping and reference-lane selection
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      seen_d   = seen_q;
      off_d    = off_q;
      err_d    = 1'b0;
      load_c   = 1'b0;
      en_c     = (state_q == IDLE) ? lanes_en_i : mask_q;
      maxoff_c = '0;
      ref_d    = '0;
      found_c  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            seen_d = '0;
            off_d  = '0;
            if ((bytes_valid_i & lanes_en_i) != '0) begin
               seen_d = bytes_valid_i & lanes_en_i;
               if (seen_d == lanes_en_i) begin
                  state_d = ALIGNED;
                  load_c  = 1'b1;
               end else begin
                  state_d = ARM;
                  cnt_d   = 4'd1;
               end
            end
         end
         ARM: begin
            for (int k = 0; k < LANES; k++) begin
               if (mask_q[k] && bytes_valid_i[k] && !seen_q[k]) begin
                  seen_d[k] = 1'b1;
                  off_d[k]  = cnt_q;
               end
            end
            if ((seen_d & mask_q) == mask_q) begin
               state_d = ALIGNED;
               load_c  = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ERROR;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ALIGNED: begin
            if (!bytes_valid_i[ref_q])
               state_d = ((bytes_valid_i & mask_q) == '0) ? IDLE : DRAIN;
         end
         DRAIN, ERROR: begin
            if ((bytes_valid_i & mask_q) == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Latest arrival wins; ties go to the lowest lane index
      for (int k = 0; k < LANES; k++) begin
         if (en_c[k] && (!found_c || off_d[k] > maxoff_c)) begin
            found_c  = 1'b1;
            maxoff_c = off_d[k];
            ref_d    = RW'(k);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         seen_q  <= '0;
         off_q   <= '0;
         mask_q  <= '0;
         ref_q   <= '0;
         tap_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         seen_q  <= seen_d;
         off_q   <= off_d;
         if (state_q == IDLE && state_d != IDLE) mask_q <= lanes_en_i;
         if (load_c) begin
            ref_q <= ref_d;
            for (int k = 0; k < LANES; k++)
               tap_q[k] <= en_c[k] ? TW'(maxoff_c - off_d[k]) : '0;
         end
      end
   end

   // Shared delay line, free-running in every state
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < ALIGN_DEPTH; i++) dly_q[i] <= '0;
      end else begin
         dly_q[0] <= byte_i;
         for (int i = 1; i < ALIGN_DEPTH; i++) dly_q[i] <= dly_q[i-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lane_valid_o <= 1'b0;
         lane_byte_o  <= '0;
         lane_skew_o  <= '0;
         skew_err_o   <= 1'b0;
      end else begin
         lane_valid_o <= (state_q == ALIGNED);
         skew_err_o   <= err_d;
         if (state_q == ALIGNED) begin
            for (int k = 0; k < LANES; k++)
               lane_byte_o[8*k +: 8] <= mask_q[k] ? dly_q[tap_q[k]][8*k +: 8] : 8'h00;
         end
         if (load_c) begin
            for (int k = 0; k < LANES; k++)
               lane_skew_o[4*k +: 4] <= en_c[k] ? off_d[k] : 4'h0;
         end
      end
   end

endmodule

// File: tb/tb_mipi_rx_lane_deskew.sv
// Bench for mipi_rx_lane_deskew: scheduled packets with random data and offsets,
// expected words derived from lane arrival offsets and the driven byte history.
module tb_mipi_rx_lane_deskew;
   localparam int LANES = 4;
   localparam int AD    = 8;
   localparam int MAXT  = 128;
   localparam int DW    = 8 * LANES;

   logic             clk = 1'b0;
   logic             reset_i;
   logic [LANES-1:0] lanes_en_i, bytes_valid_i;
   logic [DW-1:0]    byte_i;
   logic             lane_valid_o, skew_err_o;
   logic [DW-1:0]    lane_byte_o;
   logic [4*LANES-1:0] lane_skew_o;

   always #5 clk = ~clk;

   mipi_rx_lane_deskew #(.LANES(LANES), .ALIGN_DEPTH(AD)) dut (
      .clk_i(clk), .reset_i(reset_i), .lanes_en_i(lanes_en_i),
      .bytes_valid_i(bytes_valid_i), .byte_i(byte_i), .lane_valid_o(lane_valid_o),
      .lane_byte_o(lane_byte_o), .lane_skew_o(lane_skew_o), .skew_err_o(skew_err_o));

   int checks = 0;
   int fails  = 0;

   // Stimulus schedule, captured outputs (after edge t) and expectations
   logic [LANES-1:0]   s_en [MAXT];
   logic [LANES-1:0]   s_val [MAXT];
   logic [DW-1:0]      s_byte [MAXT];
   logic               s_rst [MAXT];
   logic               cap_valid [MAXT];
   logic               cap_err [MAXT];
   logic [DW-1:0]      cap_byte [MAXT];
   logic [4*LANES-1:0] cap_skew [MAXT];
   logic               exp_valid [MAXT];
   logic               exp_err [MAXT];
   logic               exp_bchk [MAXT];
   logic [DW-1:0]      exp_byte [MAXT];
   logic [4*LANES-1:0] exp_skew [MAXT];

   int                 p_off [LANES];
   int                 p_len [LANES];
   logic [LANES-1:0]   p_en;
   logic [4*LANES-1:0] model_skew = '0;

   task automatic clear_sched(input logic [LANES-1:0] en);
      for (int t = 0; t < MAXT; t++) begin
         s_en[t] = en; s_val[t] = '0; s_rst[t] = 1'b0; s_byte[t] = DW'($urandom);
         exp_valid[t] = 1'b0; exp_err[t] = 1'b0; exp_bchk[t] = 1'b0;
         exp_byte[t] = '0; exp_skew[t] = model_skew;
      end
   endtask

   // Schedules one packet starting at cycle s and predicts its aligned output
   task automatic add_packet(input int s, input bit pat);
      int maxoff, r, e;
      logic [4*LANES-1:0] skew;
      for (int k = 0; k < LANES; k++)
         if (p_en[k])
            for (int n = 0; n < p_len[k]; n++) begin
               s_val[s+p_off[k]+n][k] = 1'b1;
               if (pat) s_byte[s+p_off[k]+n][8*k +: 8] = {4'(k), 4'(n)};
            end
      maxoff = -1; r = 0;
      for (int k = 0; k < LANES; k++)
         if (p_en[k] && p_off[k] > maxoff) begin maxoff = p_off[k]; r = k; end
      if (maxoff > AD - 1) begin
         exp_err[s+AD-1] = 1'b1;
      end else begin
         e = s + maxoff;
         skew = '0;
         for (int k = 0; k < LANES; k++) if (p_en[k]) skew[4*k +: 4] = 4'(p_off[k]);
         for (int n = 0; n < p_len[r]; n++) begin
            exp_valid[e+1+n] = 1'b1;
            exp_bchk[e+1+n]  = 1'b1;
            for (int k = 0; k < LANES; k++)
               exp_byte[e+1+n][8*k +: 8] = p_en[k] ? s_byte[s+p_off[k]+n][8*k +: 8] : 8'h00;
         end
         for (int t = e; t < MAXT; t++) exp_skew[t] = skew;
         model_skew = skew;
      end
   endtask

   task automatic rand_offs(input int maxo);
      int mn;
      mn = 99;
      for (int k = 0; k < LANES; k++) begin
         p_off[k] = p_en[k] ? int'($urandom_range(0, maxo)) : 0;
         if (p_en[k] && p_off[k] < mn) mn = p_off[k];
      end
      for (int k = 0; k < LANES; k++) if (p_en[k]) p_off[k] -= mn;
   endtask

   function automatic int pkt_end(input int s);
      int m;
      m = s;
      for (int k = 0; k < LANES; k++)
         if (p_en[k] && s + p_off[k] + p_len[k] > m) m = s + p_off[k] + p_len[k];
      return m;
   endfunction

   function automatic int max_off();
      int m;
      m = 0;
      for (int k = 0; k < LANES; k++) if (p_en[k] && p_off[k] > m) m = p_off[k];
      return m;
   endfunction

   task automatic drive(input int n);
      for (int t = 0; t < n; t++) begin
         @(negedge clk);
         reset_i = s_rst[t]; lanes_en_i = s_en[t]; bytes_valid_i = s_val[t]; byte_i = s_byte[t];
         @(posedge clk); #1;
         cap_valid[t] = lane_valid_o; cap_err[t] = skew_err_o;
         cap_byte[t]  = lane_byte_o;  cap_skew[t] = lane_skew_o;
      end
      @(negedge clk);
      reset_i = 1'b0; bytes_valid_i = '0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1; lanes_en_i = '1; bytes_valid_i = '1; byte_i = DW'($urandom);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (lane_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", lane_valid_o); end
      checks++; if (lane_byte_o !== '0) begin fails++; $display("FAIL reset_byte got %h want 0", lane_byte_o); end
      checks++; if (lane_skew_o !== '0) begin fails++; $display("FAIL reset_skew got %h want 0", lane_skew_o); end
      checks++; if (skew_err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", skew_err_o); end
      @(negedge clk);
      reset_i = 1'b0; bytes_valid_i = '0;
   endtask

   task automatic test_skewed();
      int nv;
      p_en = 4'hF; p_off = '{0, 2, 1, 3}; p_len = '{20, 20, 20, 20};
      clear_sched(p_en);
      add_packet(1, 1'b1);
      drive(30);
      nv = 0;
      for (int t = 0; t < 30; t++) begin
         checks++;
         if (cap_valid[t] !== exp_valid[t] || cap_err[t] !== exp_err[t] || cap_skew[t] !== exp_skew[t] ||
             (exp_bchk[t] && cap_byte[t] !== exp_byte[t])) begin
            fails++;
            $display("FAIL skewed t=%0d valid %b want %b err %b want %b skew %h want %h byte %h want %h",
                     t, cap_valid[t], exp_valid[t], cap_err[t], exp_err[t], cap_skew[t], exp_skew[t], cap_byte[t], exp_byte[t]);
         end
         if (cap_valid[t] === 1'b1) nv++;
      end
      checks++; if (nv !== 20) begin fails++; $display("FAIL skewed_count got %0d want 20", nv); end
      checks++; if (cap_byte[5] !== 32'h30201000) begin fails++; $display("FAIL skewed_word0 got %h want 30201000", cap_byte[5]); end
      checks++; if (cap_skew[29] !== 16'h3120) begin fails++; $display("FAIL skewed_skew got %h want 3120", cap_skew[29]); end
   endtask

   task automatic test_zero_skew();
      int nv;
      p_en = 4'hF; p_off = '{0, 0, 0, 0}; p_len = '{9, 9, 9, 9};
      clear_sched(p_en);
      add_packet(1, 1'b0);
      drive(14);
      nv = 0;
      for (int t = 0; t < 14; t++) begin
         checks++;
         if (cap_valid[t] !== exp_valid[t] || cap_err[t] !== exp_err[t] || cap_skew[t] !== exp_skew[t] ||
             (exp_bchk[t] && cap_byte[t] !== exp_byte[t])) begin
            fails++;
            $display("FAIL zero_skew t=%0d valid %b want %b err %b want %b skew %h want %h byte %h want %h",
                     t, cap_valid[t], exp_valid[t], cap_err[t], exp_err[t], cap_skew[t], exp_skew[t], cap_byte[t], exp_byte[t]);
         end
         if (cap_valid[t] === 1'b1) nv++;
      end
      checks++; if (nv !== 9) begin fails++; $display("FAIL zero_skew_count got %0d want 9", nv); end
      checks++; if (cap_valid[2] !== 1'b1) begin fails++; $display("FAIL zero_skew_start got %b want 1", cap_valid[2]); end
   endtask

   task automatic test_skew_limit();
      int ne;
      p_en = 4'hF;
      clear_sched(p_en);
      p_off = '{0, 0, 0, 7}; p_len = '{10, 10, 10, 10};
      add_packet(1, 1'b0);
      p_off = '{0, 1, 2, 8}; p_len = '{14, 14, 14, 14};
      add_packet(20, 1'b0);
      drive(46);
      ne = 0;
      for (int t = 0; t < 46; t++) begin
         checks++;
         if (cap_valid[t] !== exp_valid[t] || cap_err[t] !== exp_err[t] || cap_skew[t] !== exp_skew[t] ||
             (exp_bchk[t] && cap_byte[t] !== exp_byte[t])) begin
            fails++;
            $display("FAIL skew_limit t=%0d valid %b want %b err %b want %b skew %h want %h byte %h want %h",
                     t, cap_valid[t], exp_valid[t], cap_err[t], exp_err[t], cap_skew[t], exp_skew[t], cap_byte[t], exp_byte[t]);
         end
         if (cap_err[t] === 1'b1) ne++;
      end
      checks++; if (cap_skew[17][15:12] !== 4'd7) begin fails++; $display("FAIL limit_skew got %h want 7", cap_skew[17][15:12]); end
      checks++; if (ne !== 1) begin fails++; $display("FAIL err_pulses got %0d want 1", ne); end
      checks++; if (cap_skew[45] !== 16'h7000) begin fails++; $display("FAIL skew_after_err got %h want 7000", cap_skew[45]); end
   endtask

   task automatic test_two_lane();
      int n;
      logic [15:0] upper;
      p_en = 4'b0011;
      rand_offs(7);
      for (int k = 0; k < LANES; k++) p_len[k] = int'($urandom_range(5, 12));
      clear_sched(p_en);
      for (int t = 0; t < MAXT; t++) s_val[t] = {2'($urandom), 2'b00};
      add_packet(1, 1'b0);
      n = pkt_end(1) + 4;
      drive(n);
      upper = '0;
      for (int t = 0; t < n; t++) begin
         checks++;
         if (cap_valid[t] !== exp_valid[t] || cap_err[t] !== exp_err[t] || cap_skew[t] !== exp_skew[t] ||
             (exp_bchk[t] && cap_byte[t] !== exp_byte[t])) begin
            fails++;
            $display("FAIL two_lane t=%0d valid %b want %b err %b want %b skew %h want %h byte %h want %h",
                     t, cap_valid[t], exp_valid[t], cap_err[t], exp_err[t], cap_skew[t], exp_skew[t], cap_byte[t], exp_byte[t]);
         end
         if (cap_valid[t] === 1'b1) upper |= cap_byte[t][31:16];
      end
      checks++; if (upper !== 16'h0) begin fails++; $display("FAIL two_lane_upper got %h want 0000", upper); end
   endtask

   task automatic test_ref_end();
      p_en = 4'hF; p_off = '{0, 1, 2, 3}; p_len = '{15, 12, 13, 12};
      clear_sched(p_en);
      add_packet(1, 1'b0);
      drive(22);
      for (int t = 0; t < 22; t++) begin
         checks++;
         if (cap_valid[t] !== exp_valid[t] || cap_err[t] !== exp_err[t] || cap_skew[t] !== exp_skew[t] ||
             (exp_bchk[t] && cap_byte[t] !== exp_byte[t])) begin
            fails++;
            $display("FAIL ref_end t=%0d valid %b want %b err %b want %b skew %h want %h byte %h want %h",
                     t, cap_valid[t], exp_valid[t], cap_err[t], exp_err[t], cap_skew[t], exp_skew[t], cap_byte[t], exp_byte[t]);
         end
      end
      checks++; if (cap_valid[16] !== 1'b1) begin fails++; $display("FAIL ref_last_word got %b want 1", cap_valid[16]); end
      checks++; if (cap_valid[17] !== 1'b0) begin fails++; $display("FAIL ref_fall got %b want 0", cap_valid[17]); end
   endtask

   task automatic test_reset_mid();
      int n;
      p_en = 4'hF;
      clear_sched(p_en);
      rand_offs(5);
      for (int k = 0; k < LANES; k++) p_len[k] = 15 - (1 + p_off[k]);
      add_packet(1, 1'b0);
      s_rst[15] = 1'b1;
      for (int t = 15; t < MAXT; t++) begin
         exp_valid[t] = 1'b0; exp_bchk[t] = 1'b0; exp_skew[t] = '0;
      end
      exp_bchk[15] = 1'b1; exp_byte[15] = '0;
      model_skew = '0;
      rand_offs(7);
      for (int k = 0; k < LANES; k++) p_len[k] = int'($urandom_range(4, 10));
      add_packet(18, 1'b0);
      n = pkt_end(18) + 4;
      drive(n);
      for (int t = 0; t < n; t++) begin
         checks++;
         if (cap_valid[t] !== exp_valid[t] || cap_err[t] !== exp_err[t] || cap_skew[t] !== exp_skew[t] ||
             (exp_bchk[t] && cap_byte[t] !== exp_byte[t])) begin
            fails++;
            $display("FAIL reset_mid t=%0d valid %b want %b err %b want %b skew %h want %h byte %h want %h",
                     t, cap_valid[t], exp_valid[t], cap_err[t], exp_err[t], cap_skew[t], exp_skew[t], cap_byte[t], exp_byte[t]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int s2, n;
      for (int i = 0; i < 3; i++) begin
         p_en = 4'hF;
         clear_sched(p_en);
         rand_offs(7);
         for (int k = 0; k < LANES; k++) p_len[k] = int'($urandom_range(3, 10));
         add_packet(1, 1'b0);
         s2 = pkt_end(1) + 1;
         rand_offs(7);
         for (int k = 0; k < LANES; k++) p_len[k] = int'($urandom_range(3, 10));
         add_packet(s2, 1'b0);
         n = pkt_end(s2) + 4;
         drive(n);
         for (int t = 0; t < n; t++) begin
            checks++;
            if (cap_valid[t] !== exp_valid[t] || cap_err[t] !== exp_err[t] || cap_skew[t] !== exp_skew[t] ||
                (exp_bchk[t] && cap_byte[t] !== exp_byte[t])) begin
               fails++;
               $display("FAIL back_to_back i=%0d t=%0d valid %b want %b err %b want %b skew %h want %h byte %h want %h",
                        i, t, cap_valid[t], exp_valid[t], cap_err[t], exp_err[t], cap_skew[t], exp_skew[t], cap_byte[t], exp_byte[t]);
            end
         end
      end
   endtask

   task automatic test_random();
      int n;
      for (int i = 0; i < 8; i++) begin
         p_en = 4'($urandom_range(1, 15));
         rand_offs((i % 2 == 1) ? 9 : 7);
         for (int k = 0; k < LANES; k++) p_len[k] = (max_off() > AD - 1) ? 14 : int'($urandom_range(1, 10));
         clear_sched(p_en);
         for (int t = 0; t < MAXT; t++) s_val[t] = ~p_en & 4'($urandom);
         add_packet(1, 1'b0);
         n = pkt_end(1) + 4;
         drive(n);
         for (int t = 0; t < n; t++) begin
            checks++;
            if (cap_valid[t] !== exp_valid[t] || cap_err[t] !== exp_err[t] || cap_skew[t] !== exp_skew[t] ||
                (exp_bchk[t] && cap_byte[t] !== exp_byte[t])) begin
               fails++;
               $display("FAIL random i=%0d t=%0d valid %b want %b err %b want %b skew %h want %h byte %h want %h",
                        i, t, cap_valid[t], exp_valid[t], cap_err[t], exp_err[t], cap_skew[t], exp_skew[t], cap_byte[t], exp_byte[t]);
            end
         end
      end
   endtask

   initial begin
      reset_i = 1'b1; lanes_en_i = '0; bytes_valid_i = '0; byte_i = '0;
      test_reset();
      test_skewed();
      test_zero_skew();
      test_skew_limit();
      test_two_lane();
      test_ref_end();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
